// File: rtl/dma64_pkg.sv
// dma64_pkg: shared definitions for the 64-bit DMA memory responder.
// Holds the FSM state encoding, element size codes and beat width.
package dma64_pkg;

   localparam int BEAT_W = 64;

   localparam logic [2:0] SIZE_WORD  = 3'b010;
   localparam logic [2:0] SIZE_DWORD = 3'b011;

   typedef enum logic [1:0] {
      IDLE,
      ACCEPT,
      RD,
      WR
   } state_e;

endpackage

// File: rtl/dma64_skid_fifo.sv
// dma64_skid_fifo: 2-entry, 64-bit skid buffer for the read channel.
// The memory read lands directly in the storage slot on the next edge.
module dma64_skid_fifo
   import dma64_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [BEAT_W-1:0] wdata_i,
   input  logic              pop_i,
   output logic [BEAT_W-1:0] rdata_o,
   output logic [1:0]        count_o
);

   logic [BEAT_W-1:0] stor_q [2];
   logic              wp_q;
   logic              rp_q;
   logic [1:0]        cnt_q;

   // Storage, pointers and occupancy; cleared on reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         stor_q[0] <= '0;
         stor_q[1] <= '0;
         wp_q      <= 1'b0;
         rp_q      <= 1'b0;
         cnt_q     <= 2'd0;
      end else begin
         if (push_i) begin
            stor_q[wp_q] <= wdata_i;
            wp_q         <= ~wp_q;
         end
         if (pop_i) begin
            rp_q <= ~rp_q;
         end
         cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   assign rdata_o = stor_q[rp_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/dma64_mem_responder.sv
// dma64_mem_responder: system-side 64-bit DMA memory model with backdoor.
// Define DMA_RESP_STALL_EN to enable LFSR-driven flow stalls.
module dma64_mem_responder
   import dma64_pkg::*;
#(
   parameter int          DEPTH      = 16384,
   parameter int          AW         = 14,
   parameter logic [15:0] STALL_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dma_read_ctrl_valid,
   input  logic [31:0]       dma_read_ctrl_data_index,
   input  logic [31:0]       dma_read_ctrl_data_length,
   input  logic [2:0]        dma_read_ctrl_data_size,
   output logic              dma_read_ctrl_ready,
   output logic              dma_read_chnl_valid,
   output logic [BEAT_W-1:0] dma_read_chnl_data,
   input  logic              dma_read_chnl_ready,
   input  logic              dma_write_ctrl_valid,
   input  logic [31:0]       dma_write_ctrl_data_index,
   input  logic [31:0]       dma_write_ctrl_data_length,
   input  logic [2:0]        dma_write_ctrl_data_size,
   output logic              dma_write_ctrl_ready,
   input  logic              dma_write_chnl_valid,
   input  logic [BEAT_W-1:0] dma_write_chnl_data,
   output logic              dma_write_chnl_ready,
   input  logic              bd_we,
   input  logic [AW-1:0]     bd_addr,
   input  logic [BEAT_W-1:0] bd_wdata,
   output logic [BEAT_W-1:0] bd_rdata,
   output logic              busy,
   output logic [2:0]        last_size,
   output logic [15:0]       txn_count
);

   logic [BEAT_W-1:0] mem [DEPTH];

   state_e            state_q;
   logic              rd_rdy_q;
   logic              wr_rdy_q;
   logic              is_wr_q;
   logic              busy_q;
   logic [AW-1:0]     addr_q;
   logic [31:0]       rem_q;
   logic [2:0]        size_q;
   logic [15:0]       txn_q;
   logic [BEAT_W-1:0] bd_rdata_q;

   logic              gate;
   logic [1:0]        fifo_cnt;
   logic [BEAT_W-1:0] fifo_head;
   logic              rd_issue;
   logic              rd_pop;
   logic              wr_rdy;
   logic              wr_fire;
   logic [31:0]       acc_idx;
   logic [31:0]       acc_len;
   logic [2:0]        acc_size;
   logic              unused_bits;

`ifdef DMA_RESP_STALL_EN
   logic [15:0] lfsr_q;

   // Free-running stall pattern; bit 0 throttles issue, accept and ctrl
   always_ff @(posedge clk) begin
      if (!rst) begin
         lfsr_q <= STALL_SEED;
      end else begin
         lfsr_q <= {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   assign gate = lfsr_q[0];
`else
   logic unused_seed;

   assign gate        = 1'b0;
   assign unused_seed = ^STALL_SEED;
`endif

   assign unused_bits = ^{dma_read_ctrl_data_index[31:AW],
                          dma_write_ctrl_data_index[31:AW],
                          SIZE_WORD, SIZE_DWORD};

   assign acc_idx  = is_wr_q ? dma_write_ctrl_data_index
                             : dma_read_ctrl_data_index;
   assign acc_len  = is_wr_q ? dma_write_ctrl_data_length
                             : dma_read_ctrl_data_length;
   assign acc_size = is_wr_q ? dma_write_ctrl_data_size
                             : dma_read_ctrl_data_size;

   assign rd_issue = (state_q == RD) && (rem_q != '0)
                     && (fifo_cnt < 2'd2) && !gate;
   assign dma_read_chnl_valid = (fifo_cnt != 2'd0);
   assign rd_pop   = dma_read_chnl_valid && dma_read_chnl_ready;
   assign wr_rdy   = (state_q == WR) && (rem_q != '0) && !gate;
   assign wr_fire  = wr_rdy && dma_write_chnl_valid;

   dma64_skid_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rd_issue),
      .wdata_i (mem[addr_q]),
      .pop_i   (rd_pop),
      .rdata_o (fifo_head),
      .count_o (fifo_cnt)
   );

   // Memory write port: DMA beats, else backdoor when idle; no reset
   always_ff @(posedge clk) begin
      if (rst && wr_fire) begin
         mem[addr_q] <= dma_write_chnl_data;
      end else if (bd_we && !busy_q) begin
         mem[bd_addr] <= bd_wdata;
      end
   end

   // Backdoor read port with one cycle of latency
   always_ff @(posedge clk) begin
      if (!rst) begin
         bd_rdata_q <= '0;
      end else begin
         bd_rdata_q <= mem[bd_addr];
      end
   end

   // Request arbitration, transfer sequencing and status registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         rd_rdy_q <= 1'b0;
         wr_rdy_q <= 1'b0;
         is_wr_q  <= 1'b0;
         busy_q   <= 1'b0;
         addr_q   <= '0;
         rem_q    <= '0;
         size_q   <= '0;
         txn_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (dma_write_ctrl_valid && !gate) begin
                  wr_rdy_q <= 1'b1;
                  is_wr_q  <= 1'b1;
                  state_q  <= ACCEPT;
               end else if (dma_read_ctrl_valid && !gate) begin
                  rd_rdy_q <= 1'b1;
                  is_wr_q  <= 1'b0;
                  state_q  <= ACCEPT;
               end
            end
            ACCEPT: begin
               rd_rdy_q <= 1'b0;
               wr_rdy_q <= 1'b0;
               addr_q   <= acc_idx[AW-1:0];
               rem_q    <= acc_len;
               size_q   <= acc_size;
               if (acc_len == '0) begin
                  state_q <= IDLE;
                  txn_q   <= txn_q + 16'd1;
               end else begin
                  state_q <= is_wr_q ? WR : RD;
                  busy_q  <= 1'b1;
               end
            end
            RD: begin
               if (rd_issue) begin
                  addr_q <= addr_q + 1'b1;
                  rem_q  <= rem_q - 32'd1;
               end
               if (rem_q == '0 && fifo_cnt == 2'd0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  txn_q   <= txn_q + 16'd1;
               end
            end
            WR: begin
               if (wr_fire) begin
                  addr_q <= addr_q + 1'b1;
                  rem_q  <= rem_q - 32'd1;
               end
               if (rem_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  txn_q   <= txn_q + 16'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dma_read_ctrl_ready  = rd_rdy_q;
   assign dma_write_ctrl_ready = wr_rdy_q;
   assign dma_read_chnl_data   = fifo_head;
   assign dma_write_chnl_ready = wr_rdy;
   assign bd_rdata             = bd_rdata_q;
   assign busy                 = busy_q;
   assign last_size            = size_q;
   assign txn_count            = txn_q;

endmodule

// File: tb/tb_dma64_mem_responder.sv
// tb_dma64_mem_responder: directed bench for the DMA memory responder.
// Drives and samples on the falling clock edge.
module tb_dma64_mem_responder;

   logic        clk;
   logic        rst;
   logic        dma_read_ctrl_valid;
   logic [31:0] dma_read_ctrl_data_index;
   logic [31:0] dma_read_ctrl_data_length;
   logic [2:0]  dma_read_ctrl_data_size;
   logic        dma_read_ctrl_ready;
   logic        dma_read_chnl_valid;
   logic [63:0] dma_read_chnl_data;
   logic        dma_read_chnl_ready;
   logic        dma_write_ctrl_valid;
   logic [31:0] dma_write_ctrl_data_index;
   logic [31:0] dma_write_ctrl_data_length;
   logic [2:0]  dma_write_ctrl_data_size;
   logic        dma_write_ctrl_ready;
   logic        dma_write_chnl_valid;
   logic [63:0] dma_write_chnl_data;
   logic        dma_write_chnl_ready;
   logic        bd_we;
   logic [13:0] bd_addr;
   logic [63:0] bd_wdata;
   logic [63:0] bd_rdata;
   logic        busy;
   logic [2:0]  last_size;
   logic [15:0] txn_count;

   int checks = 0;
   int errors = 0;
   logic [63:0] expq [$];

   dma64_mem_responder dut (
      .clk                        (clk),
      .rst                        (rst),
      .dma_read_ctrl_valid        (dma_read_ctrl_valid),
      .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
      .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
      .dma_read_ctrl_data_size    (dma_read_ctrl_data_size),
      .dma_read_ctrl_ready        (dma_read_ctrl_ready),
      .dma_read_chnl_valid        (dma_read_chnl_valid),
      .dma_read_chnl_data         (dma_read_chnl_data),
      .dma_read_chnl_ready        (dma_read_chnl_ready),
      .dma_write_ctrl_valid       (dma_write_ctrl_valid),
      .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
      .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
      .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
      .dma_write_ctrl_ready       (dma_write_ctrl_ready),
      .dma_write_chnl_valid       (dma_write_chnl_valid),
      .dma_write_chnl_data        (dma_write_chnl_data),
      .dma_write_chnl_ready       (dma_write_chnl_ready),
      .bd_we                      (bd_we),
      .bd_addr                    (bd_addr),
      .bd_wdata                   (bd_wdata),
      .bd_rdata                   (bd_rdata),
      .busy                       (busy),
      .last_size                  (last_size),
      .txn_count                  (txn_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] wd(input int i);
      return {16'hCAFE, 16'(i), 32'(i * 7 + 1)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bd_write(input logic [13:0] a, input logic [63:0] d);
      bd_we    = 1'b1;
      bd_addr  = a;
      bd_wdata = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic bd_check(input string tag, input logic [13:0] a,
                           input logic [63:0] d);
      bd_addr = a;
      @(negedge clk);
      chk(tag, bd_rdata, d);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_flags"},
          {40'd0, dma_read_ctrl_ready, dma_write_ctrl_ready,
           dma_read_chnl_valid, dma_write_chnl_ready, busy,
           last_size, txn_count}, 64'd0);
      chk({tag, "_rdata"}, dma_read_chnl_data, 64'd0);
      chk({tag, "_bd_rdata"}, bd_rdata, 64'd0);
   endtask

   task automatic ctrl(input bit wr, input logic [31:0] idx,
                       input logic [31:0] len, input logic [2:0] sz);
      int  n = 0;
      bit  seen = 1'b0;
      if (wr) begin
         dma_write_ctrl_data_index  = idx;
         dma_write_ctrl_data_length = len;
         dma_write_ctrl_data_size   = sz;
         dma_write_ctrl_valid       = 1'b1;
      end else begin
         dma_read_ctrl_data_index  = idx;
         dma_read_ctrl_data_length = len;
         dma_read_ctrl_data_size   = sz;
         dma_read_ctrl_valid       = 1'b1;
      end
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         seen = wr ? dma_write_ctrl_ready : dma_read_ctrl_ready;
      end
      chk(wr ? "wr_ctrl_ack" : "rd_ctrl_ack", 64'(seen), 64'd1);
      @(negedge clk);
      chk("ctrl_pulse",
          64'(wr ? dma_write_ctrl_ready : dma_read_ctrl_ready), 64'd0);
      chk("busy_after_accept", 64'(busy), 64'(len != 0));
      if (wr) dma_write_ctrl_valid = 1'b0;
      else    dma_read_ctrl_valid  = 1'b0;
   endtask

   task automatic read_beats(input int n, input bit toggle, output int cyc);
      int          got = 0;
      int          k = 0;
      bit          stalled = 1'b0;
      bit          r;
      logic [63:0] held = '0;
      cyc = 0;
      while (got < n && cyc < 2000) begin
         r = toggle ? (k % 3 == 0) : 1'b1;
         k++;
         dma_read_chnl_ready = r;
         if (stalled) begin
            chk("rd_hold_valid", 64'(dma_read_chnl_valid), 64'd1);
            chk("rd_hold_data", dma_read_chnl_data, held);
         end
         stalled = 1'b0;
         if (dma_read_chnl_valid) begin
            if (r) begin
               chk($sformatf("rd_beat%0d", got), dma_read_chnl_data,
                   expq[got]);
               got++;
            end else begin
               stalled = 1'b1;
               held    = dma_read_chnl_data;
            end
         end
         @(negedge clk);
         cyc++;
      end
      dma_read_chnl_ready = 1'b0;
      chk("rd_count", 64'(got), 64'(n));
      chk("rd_no_extra", 64'(dma_read_chnl_valid), 64'd0);
   endtask

   initial begin
      int  cyc;
      int  i;
      int  wc;
      bit  fire;
      bit  ph;
      bit  flag;

      rst = 1'b0;
      dma_read_ctrl_valid        = 1'b0;
      dma_read_ctrl_data_index   = '0;
      dma_read_ctrl_data_length  = '0;
      dma_read_ctrl_data_size    = '0;
      dma_read_chnl_ready        = 1'b0;
      dma_write_ctrl_valid       = 1'b0;
      dma_write_ctrl_data_index  = '0;
      dma_write_ctrl_data_length = '0;
      dma_write_ctrl_data_size   = '0;
      dma_write_chnl_valid       = 1'b0;
      dma_write_chnl_data        = '0;
      bd_we    = 1'b0;
      bd_addr  = '0;
      bd_wdata = '0;

      repeat (3) @(negedge clk);
      chk_all_zero("reset0");
      rst = 1'b1;
      @(negedge clk);

      for (int j = 0; j < 128; j++) bd_write(14'(10000 + j), 64'(j));
      bd_write(14'd16382, 64'h1111_0000_0000_0001);
      bd_write(14'd16383, 64'h1111_0000_0000_0002);
      bd_write(14'd0,     64'h1111_0000_0000_0003);
      bd_write(14'd1,     64'h1111_0000_0000_0004);
      bd_check("bd_preload", 14'd10005, 64'd5);

      // 128-beat read at full rate
      expq.delete();
      for (int j = 0; j < 128; j++) expq.push_back(64'(j));
      ctrl(1'b0, 32'd10000, 32'd128, 3'b011);
      read_beats(128, 1'b0, cyc);
      chk("rd128_cycles", 64'(cyc), 64'd129);
      repeat (2) @(negedge clk);
      chk("rd128_txn", 64'(txn_count), 64'd1);
      chk("rd128_busy", 64'(busy), 64'd0);
      chk("rd128_size", 64'(last_size), 64'd3);

      // 376-beat write, initiator valid alternating
      ctrl(1'b1, 32'd10000, 32'd376, 3'b010);
      i = 0;
      wc = 0;
      ph = 1'b1;
      bd_addr  = 14'd10001;
      bd_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
      while (i < 376 && wc < 2000) begin
         dma_write_chnl_valid = ph;
         dma_write_chnl_data  = wd(i);
         bd_we = (i == 300);
         fire  = ph && dma_write_chnl_ready;
         @(negedge clk);
         wc++;
         if (fire) i++;
         ph = !ph;
      end
      dma_write_chnl_valid = 1'b0;
      bd_we = 1'b0;
      chk("wr376_beats", 64'(i), 64'd376);
      chk("wr376_ready_fall", 64'(dma_write_chnl_ready), 64'd0);
      repeat (2) @(negedge clk);
      chk("wr376_txn", 64'(txn_count), 64'd2);
      chk("wr376_size", 64'(last_size), 64'd2);
      for (int j = 0; j < 376; j++)
         bd_check($sformatf("wr_mem%0d", j), 14'(10000 + j), wd(j));

      // Simultaneous requests: write wins, read waits
      dma_write_ctrl_data_index  = 32'd2000;
      dma_write_ctrl_data_length = 32'd3;
      dma_write_ctrl_data_size   = 3'b011;
      dma_write_ctrl_valid       = 1'b1;
      dma_read_ctrl_data_index   = 32'd10000;
      dma_read_ctrl_data_length  = 32'd2;
      dma_read_ctrl_data_size    = 3'b010;
      dma_read_ctrl_valid        = 1'b1;
      @(negedge clk);
      chk("prio_wr_ready", 64'(dma_write_ctrl_ready), 64'd1);
      chk("prio_rd_wait", 64'(dma_read_ctrl_ready), 64'd0);
      @(negedge clk);
      dma_write_ctrl_valid = 1'b0;
      flag = 1'b0;
      for (int b = 0; b < 3; b++) begin
         dma_write_chnl_valid = 1'b1;
         dma_write_chnl_data  = wd(500 + b);
         flag |= dma_read_ctrl_ready;
         @(negedge clk);
      end
      dma_write_chnl_valid = 1'b0;
      chk("prio_rd_early", 64'(flag), 64'd0);
      expq.delete();
      expq.push_back(wd(0));
      expq.push_back(wd(1));
      ctrl(1'b0, 32'd10000, 32'd2, 3'b010);
      chk("prio_wr_done_txn", 64'(txn_count), 64'd3);
      read_beats(2, 1'b0, cyc);
      repeat (2) @(negedge clk);
      chk("prio_txn", 64'(txn_count), 64'd4);
      chk("prio_size", 64'(last_size), 64'd2);
      for (int j = 0; j < 3; j++)
         bd_check($sformatf("prio_mem%0d", j), 14'(2000 + j), wd(500 + j));

      // Read of 8 with ready pattern 1,0,0
      expq.delete();
      for (int j = 0; j < 8; j++) expq.push_back(wd(100 + j));
      ctrl(1'b0, 32'd10100, 32'd8, 3'b011);
      read_beats(8, 1'b1, cyc);
      repeat (2) @(negedge clk);
      chk("tog_txn", 64'(txn_count), 64'd5);

      // Read across the top of memory, index beyond DEPTH
      expq.delete();
      expq.push_back(64'h1111_0000_0000_0001);
      expq.push_back(64'h1111_0000_0000_0002);
      expq.push_back(64'h1111_0000_0000_0003);
      expq.push_back(64'h1111_0000_0000_0004);
      ctrl(1'b0, 32'h0001_3FFE, 32'd4, 3'b011);
      read_beats(4, 1'b0, cyc);
      repeat (2) @(negedge clk);
      chk("wrap_txn", 64'(txn_count), 64'd6);

      // Zero-length request
      ctrl(1'b0, 32'd10000, 32'd0, 3'b010);
      flag = 1'b0;
      dma_read_chnl_ready = 1'b1;
      repeat (4) begin
         flag |= dma_read_chnl_valid | busy;
         @(negedge clk);
      end
      dma_read_chnl_ready = 1'b0;
      chk("len0_no_beats", 64'(flag), 64'd0);
      chk("len0_txn", 64'(txn_count), 64'd7);

      // Reset in the middle of a 64-beat read
      ctrl(1'b0, 32'd10000, 32'd64, 3'b011);
      dma_read_chnl_ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("mid_busy", 64'(busy), 64'd1);
      rst = 1'b0;
      @(negedge clk);
      chk_all_zero("reset1");
      @(negedge clk);
      rst = 1'b1;
      flag = 1'b0;
      repeat (4) begin
         flag |= dma_read_chnl_valid | busy;
         @(negedge clk);
      end
      dma_read_chnl_ready = 1'b0;
      chk("post_rst_quiet", 64'(flag), 64'd0);
      chk("post_rst_txn", 64'(txn_count), 64'd0);
      for (int j = 0; j < 4; j++)
         bd_check($sformatf("keep_mem%0d", j), 14'(10000 + j), wd(j));
      bd_check("keep_wrap", 14'd16382, 64'h1111_0000_0000_0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
